// File: rtl/keypad_scan_if.sv
// Keypad row/column lines plus the key-event and entry-buffer outputs.
// Combinational bundle, no latency of its own.
// No backpressure; every output is a level or a single-cycle pulse.
`timescale 1ns/1ps
interface keypad_scan_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [23:0] dig_bcd;
    logic        load;

    modport master (
        input  col,
        output row, key_code, key_valid, key_held, dig_bcd, load
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_held, dig_bcd, load
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with per-key debounce and a 6-digit BCD entry buffer.
// Latency: 2-cycle col sync, then DEBOUNCE_MS cycles from dwell sample to key_valid.
// No backpressure: key_valid/load are one-shot pulses the consumer must catch.
`timescale 1ns/1ps
module keypad_scan #(
    parameter int DEBOUNCE_MS = 20,
    parameter int DWELL       = 4
) (
    input  logic          clk1k,
    input  logic          rst,
    keypad_scan_if.master kp
);
    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_MS - 1);

    state_t      state, state_nx;
    logic [3:0]  col_m, col_s;
    logic [3:0]  dwell_cnt, dwell_nx;
    logic [1:0]  row_idx, row_nx;
    logic [7:0]  deb_cnt, deb_nx;
    logic [1:0]  col_lat, col_lat_nx;
    logic [3:0]  key_code_r, key_code_nx;
    logic        key_valid_r, key_valid_nx;
    logic        key_held_r, key_held_nx;
    logic        load_r, load_nx;
    logic [23:0] dig_r, dig_nx;
    logic        single;
    logic [1:0]  col_idx;
    logic        match;
    logic [3:0]  code_new;

    // Exactly one column low is a usable sample; anything else is idle or a ghost.
    always_comb begin
        single  = 1'b1;
        col_idx = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: single  = 1'b0;
        endcase
    end

    assign match    = (col_s == ~(4'b0001 << col_lat));
    assign code_new = {row_idx, col_lat};

    always_comb begin
        state_nx     = state;
        dwell_nx     = dwell_cnt;
        row_nx       = row_idx;
        deb_nx       = deb_cnt;
        col_lat_nx   = col_lat;
        key_code_nx  = key_code_r;
        key_valid_nx = 1'b0;
        key_held_nx  = key_held_r;
        load_nx      = 1'b0;
        dig_nx       = dig_r;
        case (state)
            SCAN: begin
                if (dwell_cnt == DWELL_LAST) begin
                    if (single) begin
                        col_lat_nx = col_idx;
                        deb_nx     = 8'd0;
                        state_nx   = DEB_PRESS;
                    end else begin
                        dwell_nx = 4'd0;
                        row_nx   = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell_cnt + 4'd1;
                end
            end
            DEB_PRESS: begin
                if (match) begin
                    deb_nx = deb_cnt + 8'd1;
                    if (deb_cnt == DEB_LAST) begin
                        state_nx     = PRESSED;
                        key_code_nx  = code_new;
                        key_valid_nx = 1'b1;
                        key_held_nx  = 1'b1;
                        if (code_new <= 4'd9)
                            dig_nx = {dig_r[19:0], code_new};
                        else if (code_new == 4'hA)
                            dig_nx = 24'h000000;
                        else if (code_new == 4'hB)
                            load_nx = 1'b1;
                    end
                end else begin
                    state_nx = SCAN;
                    row_nx   = row_idx + 2'd1;
                    dwell_nx = 4'd0;
                end
            end
            PRESSED: begin
                if (col_s == 4'hF) begin
                    deb_nx   = 8'd0;
                    state_nx = DEB_REL;
                end
            end
            DEB_REL: begin
                if (col_s == 4'hF) begin
                    deb_nx = deb_cnt + 8'd1;
                    if (deb_cnt == DEB_LAST) begin
                        key_held_nx = 1'b0;
                        state_nx    = SCAN;
                        row_nx      = row_idx + 2'd1;
                        dwell_nx    = 4'd0;
                    end
                end else begin
                    deb_nx = 8'd0;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk1k or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            col_m       <= 4'hF;
            col_s       <= 4'hF;
            dwell_cnt   <= 4'd0;
            row_idx     <= 2'd0;
            deb_cnt     <= 8'd0;
            col_lat     <= 2'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            load_r      <= 1'b0;
            dig_r       <= 24'h000000;
        end else begin
            state       <= state_nx;
            col_m       <= kp.col;
            col_s       <= col_m;
            dwell_cnt   <= dwell_nx;
            row_idx     <= row_nx;
            deb_cnt     <= deb_nx;
            col_lat     <= col_lat_nx;
            key_code_r  <= key_code_nx;
            key_valid_r <= key_valid_nx;
            key_held_r  <= key_held_nx;
            load_r      <= load_nx;
            dig_r       <= dig_nx;
        end
    end

    assign kp.row       = ~(4'b0001 << row_idx);
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;
    assign kp.load      = load_r;
    assign kp.dig_bcd   = dig_r;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a 4x4 key-matrix model drives col from row,
// and a timeline model of the scanner is compared with the outputs every cycle.
`timescale 1ns/1ps
module tb_keypad_scan;
    localparam int DEB = 20;
    localparam int DW  = 4;

    logic clk1k = 1'b0;
    logic rst   = 1'b0;
    always #5 clk1k = ~clk1k;

    keypad_scan_if bus();
    keypad_scan #(.DEBOUNCE_MS(DEB), .DWELL(DW)) dut (.clk1k(clk1k), .rst(rst), .kp(bus));

    logic [15:0] keys      = '0;
    logic        force_low = 1'b1;

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        bus.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.row[r] && keys[r*4+c]) bus.col[c] = 1'b0;
        if (force_low) bus.col = 4'h0;
    end

    int n_tot  = 0;
    int n_pass = 0;
    int kv_cnt = 0;
    int ld_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---- timeline model: scan position, phase and run length of samples ----
    int         m_pos, m_mode, m_run, m_val;
    logic [3:0] m_pat, m_c1, m_c2, cs;
    logic [3:0] e_code;
    logic       e_valid, e_held, e_load;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int zero_pos(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (!p[i]) return i;
        return 0;
    endfunction

    always @(posedge clk1k or negedge rst) begin
        if (!rst) begin
            m_pos = 0; m_mode = 0; m_run = 0; m_val = 0; m_pat = 4'hF;
            m_c1 = 4'hF; m_c2 = 4'hF;
            e_code = 4'd0; e_valid = 1'b0; e_held = 1'b0; e_load = 1'b0;
        end else begin
            cs = m_c2; m_c2 = m_c1; m_c1 = bus.col;
            e_valid = 1'b0; e_load = 1'b0;
            case (m_mode)
                0: if (m_pos % DW == DW - 1) begin
                       if ($countones(~cs) == 1) begin m_pat = cs; m_run = 0; m_mode = 1; end
                       else m_pos = (m_pos + 1) % (4 * DW);
                   end else m_pos = m_pos + 1;
                1: if (cs == m_pat) begin
                       m_run = m_run + 1;
                       if (m_run == DEB) begin
                           e_code = 4'((m_pos / DW) * 4 + zero_pos(m_pat));
                           e_valid = 1'b1; e_held = 1'b1; m_mode = 2;
                           if (e_code < 10) m_val = (m_val * 10 + int'(e_code)) % 1000000;
                           else if (e_code == 10) m_val = 0;
                           else if (e_code == 11) e_load = 1'b1;
                       end
                   end else begin
                       m_pos = ((m_pos / DW + 1) % 4) * DW; m_mode = 0;
                   end
                2: if (cs == 4'hF) begin m_run = 0; m_mode = 3; end
                default: if (cs == 4'hF) begin
                       m_run = m_run + 1;
                       if (m_run == DEB) begin
                           e_held = 1'b0; m_pos = ((m_pos / DW + 1) % 4) * DW; m_mode = 0;
                       end
                   end else m_run = 0;
            endcase
        end
    end

    logic [3:0] e_row;
    always @(negedge clk1k) begin
        e_row = 4'hF ^ (4'b0001 << (m_pos / DW));
        check("outputs", {bus.row, bus.key_code, bus.key_valid, bus.key_held, bus.load, bus.dig_bcd},
              {e_row, e_code, e_valid, e_held, e_load, to_bcd(m_val)});
        if (bus.key_valid) kv_cnt++;
        if (bus.load) ld_cnt++;
    end

    // ---- stimulus helpers ----
    task automatic wait_valid(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk1k);
            if (bus.key_valid) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk1k);
            if (!bus.key_held) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_row_entry(input logic [3:0] target);
        logic       ok;
        logic [3:0] prev;
        ok = 1'b0;
        prev = bus.row;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk1k);
            if (bus.row == target && prev != target) ok = 1'b1;
            prev = bus.row;
        end
        check("row_entry", ok, 1);
    endtask

    task automatic tap(input int k, input int hold);
        @(negedge clk1k);
        keys[k] = 1'b1;
        wait_valid("kv_seen");
        check("tap_code", bus.key_code, k);
        repeat (hold) @(negedge clk1k);
        keys[k] = 1'b0;
        wait_idle("tap_release");
    endtask

    int kv0, ld0;

    initial begin
        // reset with all columns pulled low
        repeat (3) @(negedge clk1k);
        check("rst_row", bus.row, 4'b1110);
        check("rst_dig", bus.dig_bcd, 24'h0);
        check("rst_kv", bus.key_valid, 0);
        check("rst_held", bus.key_held, 0);
        force_low = 1'b0;
        @(negedge clk1k);
        rst = 1'b1;
        repeat (4) @(negedge clk1k); check("rot1", bus.row, 4'b1101);
        repeat (4) @(negedge clk1k); check("rot2", bus.row, 4'b1011);
        repeat (4) @(negedge clk1k); check("rot3", bus.row, 4'b0111);
        repeat (4) @(negedge clk1k); check("rot0", bus.row, 4'b1110);

        // clean press of key 5
        kv0 = kv_cnt;
        @(negedge clk1k);
        keys[5] = 1'b1;
        wait_valid("kv5_seen");
        check("k5_code", bus.key_code, 5);
        check("k5_dig", bus.dig_bcd, 24'h000005);
        check("k5_held", bus.key_held, 1);
        repeat (40) @(negedge clk1k);
        keys[5] = 1'b0;
        repeat (22) @(negedge clk1k);
        check("held_before", bus.key_held, 1);
        @(negedge clk1k);
        check("held_after", bus.key_held, 0);
        check("k5_once", kv_cnt - kv0, 1);

        // bounce: 10 ms contact on row 1
        kv0 = kv_cnt;
        wait_row_entry(4'b1101);
        keys[5] = 1'b1;
        repeat (10) @(negedge clk1k);
        keys[5] = 1'b0;
        repeat (3) @(negedge clk1k);
        check("bounce_row2", bus.row, 4'b1011);
        check("bounce_nokv", kv_cnt - kv0, 0);

        // digit entry, clear, load
        for (int k = 1; k <= 7; k++) tap(k, 30);
        check("entry_dig", bus.dig_bcd, 24'h234567);
        tap(10, 30);
        check("clear_dig", bus.dig_bcd, 24'h0);
        tap(9, 30);
        ld0 = ld_cnt;
        tap(11, 30);
        check("load_once", ld_cnt - ld0, 1);
        check("load_dig", bus.dig_bcd, 24'h000009);

        // ghost pair on one row, then second key while one is held
        kv0 = kv_cnt;
        keys[4] = 1'b1; keys[5] = 1'b1;
        repeat (40) @(negedge clk1k);
        check("ghost_nokv", kv_cnt - kv0, 0);
        keys[4] = 1'b0; keys[5] = 1'b0;
        @(negedge clk1k);
        keys[3] = 1'b1;
        wait_valid("kv3_seen");
        check("k3_code", bus.key_code, 3);
        repeat (5) @(negedge clk1k);
        keys[7] = 1'b1;
        repeat (40) @(negedge clk1k);
        check("second_ignored", kv_cnt - kv0, 1);
        keys[3] = 1'b0;
        wait_idle("rel3");
        wait_valid("kv7_seen");
        check("k7_code", bus.key_code, 7);
        check("k7_dig", bus.dig_bcd, 24'h000937);
        keys[7] = 1'b0;
        wait_idle("rel7");

        // reset during press debounce
        kv0 = kv_cnt;
        wait_row_entry(4'b1101);
        keys[5] = 1'b1;
        repeat (10) @(negedge clk1k);
        #2 rst = 1'b0;
        #1;
        check("rd_row", bus.row, 4'b1110);
        check("rd_dig", bus.dig_bcd, 24'h0);
        check("rd_kv", bus.key_valid, 0);
        @(negedge clk1k); keys[5] = 1'b0;
        @(negedge clk1k); rst = 1'b1;
        repeat (30) @(negedge clk1k);
        check("rd_nokv", kv_cnt - kv0, 0);

        // reset while a key is held
        @(negedge clk1k);
        keys[2] = 1'b1;
        wait_valid("kv2_seen");
        check("k2_dig", bus.dig_bcd, 24'h000002);
        repeat (5) @(negedge clk1k);
        #2 rst = 1'b0;
        #1;
        check("rp_held", bus.key_held, 0);
        check("rp_dig", bus.dig_bcd, 24'h0);
        check("rp_code", bus.key_code, 0);
        check("rp_row", bus.row, 4'b1110);
        @(negedge clk1k); keys[2] = 1'b0;
        @(negedge clk1k); rst = 1'b1;
        repeat (20) @(negedge clk1k);
        check("rp_kv_total", kv_cnt - kv0, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1, "watchdog");
    end
endmodule
